// File: rtl/leaf_packet_demux_fifo.sv
// rtl/leaf_packet_demux_fifo.sv - splits BFT leaf packets by port into config/stream FIFOs
// Drops packets on full or unmapped ports; NACKs and counts them.
module leaf_packet_demux_fifo #(
  parameter int PACKET_BITS   = 97,
  parameter int NUM_LEAF_BITS = 6,
  parameter int NUM_PORT_BITS = 4,
  parameter int CFG_PORT_MAX  = 1,
  parameter int IN_PORT_MAX   = 8,
  parameter int OUT_PORT_MIN  = 9,
  parameter int FIFO_DEPTH    = 4,
  parameter int CNT_BITS      = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [PACKET_BITS-1:0]   din_leaf_bft2interface,
  output logic [PACKET_BITS-1:0]   dout_leaf_interface2bft,
  input  logic                     resend,
  output logic                     resend_out,
  input  logic [PACKET_BITS-1:0]   stream_in,
  output logic [PACKET_BITS-1:0]   stream_out,
  output logic                     stream_out_valid,
  input  logic                     stream_out_ready,
  output logic [PACKET_BITS-1:0]   configure_out,
  output logic                     configure_out_valid,
  input  logic                     configure_out_ready,
  output logic                     nack_out,
  output logic [NUM_PORT_BITS-1:0] nack_port,
  output logic [CNT_BITS-1:0]      stream_drop_cnt,
  output logic [CNT_BITS-1:0]      config_drop_cnt,
  output logic [CNT_BITS-1:0]      unmapped_cnt
);

  localparam int ADDR     = $clog2(FIFO_DEPTH);
  localparam int PORT_LSB = PACKET_BITS - 1 - NUM_LEAF_BITS - NUM_PORT_BITS;
  localparam int CFG      = 0;
  localparam int STR      = 1;

  // One extra bit so an OUT_PORT_MIN beyond the port range simply disables that class
  localparam logic [NUM_PORT_BITS:0] CFG_MAX_P = (NUM_PORT_BITS+1)'(CFG_PORT_MAX);
  localparam logic [NUM_PORT_BITS:0] IN_MAX_P  = (NUM_PORT_BITS+1)'(IN_PORT_MAX);
  localparam logic [NUM_PORT_BITS:0] OUT_MIN_P = (NUM_PORT_BITS+1)'(OUT_PORT_MIN);
  localparam logic [ADDR:0]          FULL_CNT  = (ADDR+1)'(FIFO_DEPTH);
  localparam logic [CNT_BITS-1:0]    CNT_MAX   = '1;

  logic [PACKET_BITS-1:0]   mem    [2][FIFO_DEPTH];
  logic [ADDR-1:0]          wr_ptr [2];
  logic [ADDR-1:0]          rd_ptr [2];
  logic [ADDR:0]            count  [2];

  logic [NUM_PORT_BITS-1:0] port;
  logic [NUM_PORT_BITS:0]   port_x;
  logic                     in_valid;
  logic                     is_cfg;
  logic                     is_stream;
  logic                     unmapped;
  logic [1:0]               push_req;
  logic [1:0]               push;
  logic [1:0]               pop;
  logic [1:0]               drop;
  logic [1:0]               valid;
  logic [1:0]               ready;

  assign dout_leaf_interface2bft = stream_in;
  assign resend_out              = resend;

  always_comb begin
    in_valid  = din_leaf_bft2interface[PACKET_BITS-1];
    port      = din_leaf_bft2interface[PORT_LSB +: NUM_PORT_BITS];
    port_x    = {1'b0, port};
    is_cfg    = (port_x <= CFG_MAX_P) || (port_x >= OUT_MIN_P);
    is_stream = !is_cfg && (port_x <= IN_MAX_P);
    unmapped  = in_valid && !is_cfg && !is_stream;
    push_req  = {in_valid && is_stream, in_valid && is_cfg};
    ready     = {stream_out_ready, configure_out_ready};
    valid     = '0;
    push      = '0;
    drop      = '0;
    pop       = '0;
    // Fullness looks only at the registered count: a same-cycle pop never frees room
    for (int c = 0; c < 2; c++) begin
      valid[c] = count[c] != '0;
      push[c]  = push_req[c] && (count[c] != FULL_CNT);
      drop[c]  = push_req[c] && (count[c] == FULL_CNT);
      pop[c]   = valid[c] && ready[c];
    end
  end

  always_ff @(posedge clk) begin
    for (int c = 0; c < 2; c++) begin
      if (push[c]) mem[c][wr_ptr[c]] <= din_leaf_bft2interface;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int c = 0; c < 2; c++) begin
        wr_ptr[c] <= '0;
        rd_ptr[c] <= '0;
        count[c]  <= '0;
      end
    end else begin
      for (int c = 0; c < 2; c++) begin
        if (push[c]) wr_ptr[c] <= wr_ptr[c] + ADDR'(1);
        if (pop[c])  rd_ptr[c] <= rd_ptr[c] + ADDR'(1);
        if (push[c] && !pop[c])      count[c] <= count[c] + (ADDR+1)'(1);
        else if (!push[c] && pop[c]) count[c] <= count[c] - (ADDR+1)'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      nack_out        <= 1'b0;
      nack_port       <= '0;
      stream_drop_cnt <= '0;
      config_drop_cnt <= '0;
      unmapped_cnt    <= '0;
    end else begin
      nack_out <= (|drop) || unmapped;
      if ((|drop) || unmapped) nack_port <= port;
      if (drop[STR] && stream_drop_cnt != CNT_MAX) stream_drop_cnt <= stream_drop_cnt + CNT_BITS'(1);
      if (drop[CFG] && config_drop_cnt != CNT_MAX) config_drop_cnt <= config_drop_cnt + CNT_BITS'(1);
      if (unmapped && unmapped_cnt != CNT_MAX)     unmapped_cnt    <= unmapped_cnt + CNT_BITS'(1);
    end
  end

  assign configure_out_valid = valid[CFG];
  assign stream_out_valid    = valid[STR];
  assign configure_out       = valid[CFG] ? mem[CFG][rd_ptr[CFG]] : '0;
  assign stream_out          = valid[STR] ? mem[STR][rd_ptr[STR]] : '0;

endmodule
